// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and sizing helper for the serial arithmetic blocks
package serial_arith_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Bit-counter width; never below one bit so WIDTH=1 still has a counter.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_sub_cell.sv
// rtl/bit_sub_cell.sv - combinational single-bit full subtractor
module bit_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_6bit_subtractor.sv
// rtl/serial_6bit_subtractor.sv - bit-serial a-b with borrow, LSB first, valid/ready on both sides
module serial_6bit_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] msb_in;

  bit_sub_cell u_cell (
    .x    (ra[0]),
    .y    (rb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Each result bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  assign msb_in = WIDTH'(cell_d) << (WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          rd <= (rd >> 1) | msb_in;
          ra <= ra >> 1;
          rb <= rb >> 1;
          br <= cell_bout;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign diff      = rd;
  assign borrow    = br;

endmodule

// File: tb/tb_serial_6bit_subtractor.sv
// tb/tb_serial_6bit_subtractor.sv - directed self-checking bench for serial_6bit_subtractor
module tb_serial_6bit_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a;
  logic [5:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] diff;
  logic       borrow;
  logic       busy;

  int n_checks;
  int n_fail;

  serial_6bit_subtractor #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; hold>0 keeps out_ready low for that many cycles with in_valid pulses.
  task automatic do_op(input string tag, input logic [5:0] va, input logic [5:0] vb,
                       input logic [5:0] exp_d, input logic exp_b, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    a         = va;
    b         = vb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    a        = ~va;
    b        = va ^ vb;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (lat == 3) begin
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_borrow"}, borrow, exp_b);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        a        = 6'(i);
        b        = 6'(i * 7);
        tick();
      end
      in_valid = 1'b0;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_diff"}, diff, exp_d);
      check({tag, "_hold_borrow"}, borrow, exp_b);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      out_ready = 1'b1;
    end
    tick();
    check({tag, "_done_one_cycle"}, out_valid, 0);
    check({tag, "_idle_again"}, in_ready, 1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    rst = 1'b0;
    tick();

    do_op("t9m5",   6'd9,  6'd5,  6'd4,  1'b0, 0);
    do_op("t5m9",   6'd5,  6'd9,  6'd60, 1'b1, 0);
    do_op("t0m1",   6'd0,  6'd1,  6'd63, 1'b1, 0);
    do_op("t63m63", 6'd63, 6'd63, 6'd0,  1'b0, 0);
    do_op("t0m0",   6'd0,  6'd0,  6'd0,  1'b0, 0);
    do_op("t1m63",  6'd1,  6'd63, 6'd2,  1'b1, 0);
    do_op("t63m0",  6'd63, 6'd0,  6'd63, 1'b0, 2);
    do_op("t32m33", 6'd32, 6'd33, 6'd63, 1'b1, 1);
    do_op("t42m21", 6'd42, 6'd21, 6'd21, 1'b0, 0);
    do_op("t17m50", 6'd17, 6'd50, 6'd31, 1'b1, 3);
    do_op("bp",     6'd5,  6'd9,  6'd60, 1'b1, 10);

    // Abort three cycles into SHIFT with an asynchronous mid-cycle reset.
    a        = 6'd9;
    b        = 6'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_diff", diff, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_stays_idle", out_valid, 0);
    do_op("t20m7", 6'd20, 6'd7, 6'd13, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
